// File: rtl/time_set_up_cnt.sv
// -----------------------------------------------------------------------------
// time_set_up_cnt
//
// Up-counting MM:SS entry counter used to set the countdown start value.
// Two debounced push-button levels step the seconds or the minutes field.
// Holding a button starts auto-repeat, timed from the system timebase tick.
// The four BCD digits are loaded into the down-counter chain by the
// top-level control FSM.
//
// Parameters
//   HOLD_TICKS   ce_i ticks a button must stay held before auto-repeat (>=2)
//   REPEAT_TICKS ce_i ticks between auto-repeat increments (1..HOLD_TICKS)
//   SEC_MODULO   seconds field modulo (2..100), counts 0..SEC_MODULO-1
//   MIN_MODULO   minutes field modulo (2..100), counts 0..MIN_MODULO-1
//
// Ports
//   clk_i        system clock, rising edge
//   clr_n_i      asynchronous active-low reset
//   ce_i         timebase tick, one clk_i cycle wide
//   en_i         setting-mode enable; buttons are ignored while low
//   zero_i       synchronous clear of both fields
//   btn_sec_i    debounced seconds button level, active-high
//   btn_min_i    debounced minutes button level, active-high
//   sec_ones_o   BCD seconds units
//   sec_tens_o   BCD seconds tens
//   min_ones_o   BCD minutes units
//   min_tens_o   BCD minutes tens
//   step_o       1-cycle pulse, high in the cycle the digits show a new increment
// -----------------------------------------------------------------------------
module time_set_up_cnt #(
    parameter int unsigned HOLD_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100,
    parameter int unsigned SEC_MODULO   = 60,
    parameter int unsigned MIN_MODULO   = 100
) (
    input  logic       clk_i,
    input  logic       clr_n_i,
    input  logic       ce_i,
    input  logic       en_i,
    input  logic       zero_i,
    input  logic       btn_sec_i,
    input  logic       btn_min_i,
    output logic [3:0] sec_ones_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] min_ones_o,
    output logic [3:0] min_tens_o,
    output logic       step_o
);

    localparam int unsigned CNT_W = $clog2(HOLD_TICKS + 1);

    // Highest value of each field, split into BCD digits.
    localparam logic [3:0] SEC_MAX_TENS = 4'((SEC_MODULO - 1) / 10);
    localparam logic [3:0] SEC_MAX_ONES = 4'((SEC_MODULO - 1) % 10);
    localparam logic [3:0] MIN_MAX_TENS = 4'((MIN_MODULO - 1) / 10);
    localparam logic [3:0] MIN_MAX_ONES = 4'((MIN_MODULO - 1) % 10);

    localparam logic [CNT_W-1:0] HOLD_LIMIT   = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] REPEAT_LIMIT = CNT_W'(REPEAT_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_LOCK
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic             sel_min_q,  sel_min_d;   // 1: minutes button owns the hold
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             btn_sec_q,  btn_min_q;   // previous button samples
    logic [3:0]       sec_ones_q, sec_ones_d;
    logic [3:0]       sec_tens_q, sec_tens_d;
    logic [3:0]       min_ones_q, min_ones_d;
    logic [3:0]       min_tens_q, min_tens_d;
    logic             step_q,     step_d;

    // -------------------------------------------------------------------------
    // Button edges and held-button levels
    // -------------------------------------------------------------------------
    logic             edge_sec, edge_min;
    logic             sel_level, other_level;
    logic [CNT_W-1:0] tick_inc;
    logic             fire;                    // increment the selected field

    assign edge_sec    = btn_sec_i & ~btn_sec_q;
    assign edge_min    = btn_min_i & ~btn_min_q;
    assign sel_level   = sel_min_q ? btn_min_i : btn_sec_i;
    assign other_level = sel_min_q ? btn_sec_i : btn_min_i;
    // Cannot overflow: the counter never exceeds HOLD_TICKS-1 before this add.
    assign tick_inc    = tick_cnt_q + CNT_W'(1);

    // -------------------------------------------------------------------------
    // Button FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        sel_min_d  = sel_min_q;
        tick_cnt_d = tick_cnt_q;
        fire       = 1'b0;

        if (zero_i || !en_i) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tick_cnt_d = '0;
                    if (btn_sec_i && btn_min_i) begin
                        // Simultaneous press is ambiguous: refuse until both released.
                        state_d = ST_LOCK;
                    end else if (edge_sec) begin
                        fire      = 1'b1;
                        sel_min_d = 1'b0;
                        state_d   = ST_HOLD;
                    end else if (edge_min) begin
                        fire      = 1'b1;
                        sel_min_d = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end

                ST_HOLD, ST_REPEAT: begin
                    if (!sel_level) begin
                        state_d    = ST_IDLE;
                        tick_cnt_d = '0;
                    end else if (other_level) begin
                        state_d    = ST_LOCK;
                        tick_cnt_d = '0;
                    end else if (ce_i) begin
                        if (tick_inc == ((state_q == ST_HOLD) ? HOLD_LIMIT : REPEAT_LIMIT)) begin
                            fire       = 1'b1;
                            state_d    = ST_REPEAT;
                            tick_cnt_d = '0;
                        end else begin
                            tick_cnt_d = tick_inc;
                        end
                    end
                end

                ST_LOCK: begin
                    tick_cnt_d = '0;
                    if (!btn_sec_i && !btn_min_i) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // BCD field increment. Fields wrap independently: no carry from seconds.
    // -------------------------------------------------------------------------
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        step_d     = fire;

        if (zero_i) begin
            sec_ones_d = '0;
            sec_tens_d = '0;
            min_ones_d = '0;
            min_tens_d = '0;
        end else if (fire && !sel_min_d) begin
            if (sec_tens_q == SEC_MAX_TENS && sec_ones_q == SEC_MAX_ONES) begin
                sec_ones_d = '0;
                sec_tens_d = '0;
            end else if (sec_ones_q == 4'd9) begin
                sec_ones_d = '0;
                sec_tens_d = sec_tens_q + 4'd1;
            end else begin
                sec_ones_d = sec_ones_q + 4'd1;
            end
        end else if (fire && sel_min_d) begin
            if (min_tens_q == MIN_MAX_TENS && min_ones_q == MIN_MAX_ONES) begin
                min_ones_d = '0;
                min_tens_d = '0;
            end else if (min_ones_q == 4'd9) begin
                min_ones_d = '0;
                min_tens_d = min_tens_q + 4'd1;
            end else begin
                min_ones_d = min_ones_q + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q    <= ST_IDLE;
            sel_min_q  <= 1'b0;
            tick_cnt_q <= '0;
            btn_sec_q  <= 1'b0;
            btn_min_q  <= 1'b0;
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            min_ones_q <= '0;
            min_tens_q <= '0;
            step_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            sel_min_q  <= sel_min_d;
            tick_cnt_q <= tick_cnt_d;
            btn_sec_q  <= btn_sec_i;
            btn_min_q  <= btn_min_i;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            step_q     <= step_d;
        end
    end

    assign sec_ones_o = sec_ones_q;
    assign sec_tens_o = sec_tens_q;
    assign min_ones_o = min_ones_q;
    assign min_tens_o = min_tens_q;
    assign step_o     = step_q;

endmodule

// File: tb/tb_time_set_up_cnt.sv
// -----------------------------------------------------------------------------
// tb_time_set_up_cnt
//
// Drives directed scenarios and a randomized phase into time_set_up_cnt.
// A reference model keeps the fields as plain integers and tracks how many
// ce ticks a button has been held, deriving increments arithmetically.
// -----------------------------------------------------------------------------
module tb_time_set_up_cnt;

    localparam int HOLD   = 4;
    localparam int REPEAT = 2;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 100;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       ce = 1'b0, en = 1'b0, zero = 1'b0, bs = 1'b0, bm = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       step;

    time_set_up_cnt #(
        .HOLD_TICKS  (HOLD),
        .REPEAT_TICKS(REPEAT),
        .SEC_MODULO  (SEC_MOD),
        .MIN_MODULO  (MIN_MOD)
    ) dut (
        .clk_i     (clk),
        .clr_n_i   (clr_n),
        .ce_i      (ce),
        .en_i      (en),
        .zero_i    (zero),
        .btn_sec_i (bs),
        .btn_min_i (bm),
        .sec_ones_o(sec_ones),
        .sec_tens_o(sec_tens),
        .min_ones_o(min_ones),
        .min_tens_o(min_tens),
        .step_o    (step)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int steps_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    typedef enum {M_FREE, M_HELD, M_LOCKED} mphase_e;
    mphase_e m_phase = M_FREE;
    int      m_sec = 0, m_min = 0, m_which = 0, m_ticks = 0;
    bit      m_step = 0, m_prev_s = 0, m_prev_m = 0;

    function automatic logic [15:0] m_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic m_bump(input int which);
        m_step = 1;
        if (which == 1) m_min = (m_min + 1) % MIN_MOD;
        else            m_sec = (m_sec + 1) % SEC_MOD;
    endtask

    task automatic m_reset();
        m_phase = M_FREE; m_sec = 0; m_min = 0; m_step = 0;
        m_prev_s = 0; m_prev_m = 0; m_ticks = 0;
    endtask

    task automatic m_clock();
        bit lvl, oth;
        m_step = 0;
        if (zero) begin
            m_sec = 0; m_min = 0; m_phase = M_FREE;
        end else if (!en) begin
            m_phase = M_FREE;
        end else begin
            case (m_phase)
                M_FREE: begin
                    if (bs && bm) m_phase = M_LOCKED;
                    else if (bs && !m_prev_s) begin
                        m_bump(0); m_which = 0; m_ticks = 0; m_phase = M_HELD;
                    end else if (bm && !m_prev_m) begin
                        m_bump(1); m_which = 1; m_ticks = 0; m_phase = M_HELD;
                    end
                end
                M_HELD: begin
                    lvl = (m_which == 1) ? bm : bs;
                    oth = (m_which == 1) ? bs : bm;
                    if (!lvl) m_phase = M_FREE;
                    else if (oth) m_phase = M_LOCKED;
                    else if (ce) begin
                        m_ticks++;
                        if (m_ticks == HOLD || (m_ticks > HOLD && (m_ticks - HOLD) % REPEAT == 0))
                            m_bump(m_which);
                    end
                end
                default: if (!bs && !bm) m_phase = M_FREE;
            endcase
        end
        m_prev_s = bs;
        m_prev_m = bm;
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!clr_n) m_reset();
            else        m_clock();
            #1;
            check("digits", {min_tens, min_ones, sec_tens, sec_ones}, m_digits());
            check("step", step, m_step);
            if (step === 1'b1) steps_seen++;
        end
    endtask

    task automatic press_sec();
        bs = 1; cyc(1); bs = 0; cyc(2);
    endtask

    task automatic press_min();
        bm = 1; cyc(1); bm = 0; cyc(2);
    endtask

    task automatic run_ce(input int n_ce, input int period);
        for (int i = 0; i < n_ce; i++) begin
            ce = 1; cyc(1);
            ce = 0; cyc(period - 1);
        end
    endtask

    task automatic do_zero();
        zero = 1; cyc(1); zero = 0; cyc(1);
    endtask

    logic [15:0] frozen;

    initial begin
        // Reset state
        #2;
        check("rst_async_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("rst_async_step", step, 1'b0);
        cyc(3);
        clr_n = 1; en = 1;
        cyc(2);

        // 1: three short seconds presses
        steps_seen = 0;
        repeat (3) press_sec();
        check("t1_sec", {sec_tens, sec_ones}, 8'h03);
        check("t1_min", {min_tens, min_ones}, 8'h00);
        check("t1_steps", steps_seen, 3);

        // 2: seconds wrap without carry, minutes wrap
        repeat (56) press_sec();
        check("t2_sec59", {sec_tens, sec_ones}, 8'h59);
        press_sec();
        check("t2_sec_wrap", {sec_tens, sec_ones}, 8'h00);
        check("t2_no_carry", {min_tens, min_ones}, 8'h00);
        repeat (99) press_min();
        check("t2_min99", {min_tens, min_ones}, 8'h99);
        press_min();
        check("t2_min_wrap", {min_tens, min_ones}, 8'h00);

        // 3: hold minutes for 12 ce ticks
        do_zero();
        steps_seen = 0;
        bm = 1; cyc(1);
        run_ce(12, 5);
        check("t3_min", {min_tens, min_ones}, 8'h06);
        check("t3_steps", steps_seen, 6);
        bm = 0; steps_seen = 0;
        run_ce(6, 5);
        check("t3_release_steps", steps_seen, 0);
        check("t3_min_after", {min_tens, min_ones}, 8'h06);

        // 4: simultaneous press locks out
        do_zero();
        steps_seen = 0;
        bs = 1; bm = 1; cyc(1);
        run_ce(6, 3);
        bm = 0; run_ce(6, 3);
        check("t4_lock_steps", steps_seen, 0);
        bs = 0; cyc(2);
        bs = 1; cyc(1);
        check("t4_sec", {sec_tens, sec_ones}, 8'h01);
        check("t4_step", steps_seen, 1);
        bs = 0; cyc(2);

        // 5a: zero mid-repeat, held button gives no new step
        bs = 1; cyc(1);
        run_ce(7, 3);
        zero = 1; cyc(1); zero = 0;
        check("t5_zero_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        steps_seen = 0;
        run_ce(10, 3);
        check("t5_zero_steps", steps_seen, 0);
        bs = 0; cyc(2);

        // 5b: async reset mid-hold
        press_min();
        bs = 1; cyc(1);
        run_ce(2, 3);
        clr_n = 0; #1;
        check("t5_rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("t5_rst_step", step, 1'b0);
        bs = 0; cyc(2);
        clr_n = 1; cyc(2);

        // 6: disabled buttons
        repeat (3) press_sec();
        en = 0;
        frozen = {min_tens, min_ones, sec_tens, sec_ones};
        steps_seen = 0;
        for (int i = 0; i < 200; i++) begin
            bs = 1'($urandom_range(0, 1));
            bm = 1'($urandom_range(0, 1));
            ce = ($urandom_range(0, 2) == 0);
            cyc(1);
        end
        check("t6_frozen", {min_tens, min_ones, sec_tens, sec_ones}, frozen);
        check("t6_steps", steps_seen, 0);
        bs = 0; bm = 0; ce = 0; en = 1; cyc(2);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            ce   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) bs = ~bs;
            if ($urandom_range(0, 9) == 0) bm = ~bm;
            en   = ($urandom_range(0, 49) != 0);
            zero = ($urandom_range(0, 199) == 0);
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
